// File: rtl/regfile_mp_if.sv
// Register file bus: read, write and issue ports of regfile_mp.
// slave = register file side, master = pipeline side.
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         iss_en;
    logic [ADDR_WIDTH-1:0]        iss_addr;
    logic                         any_busy;

    modport slave (
        input  rd_addr,
        output rd_data,
        output rd_busy,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  iss_en,
        input  iss_addr,
        output any_busy
    );

    modport master (
        output rd_addr,
        input  rd_data,
        input  rd_busy,
        output wr_en,
        output wr_addr,
        output wr_data,
        output iss_en,
        output iss_addr,
        input  any_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with optional bypass, zero register and busy scoreboard.
// Ports: clk, rst (sync, active-high), bus (regfile_mp_if.slave).
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;

    // Clears first, then the issue set, so a new producer
    // issued during an old writeback keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j])
                busy_nxt[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end
        if (bus.iss_en)
            busy_nxt[bus.iss_addr] = 1'b1;
        if (ZR)
            busy_nxt[0] = 1'b0;
    end

    // Later loop iterations override earlier ones, so the
    // highest-index port wins on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++)
                regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] &&
                    !(ZR && bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0))
                    regs[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]]
                        <= bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = regs[ra];
            if (BP) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] &&
                        bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra)
                        rd = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (ZR && ra == '0)
                rd = '0;
        end

        // Busy reflects registered state only; no bypass.
        always_comb begin
            rb = busy[ra];
            if (ZR && ra == '0)
                rb = 1'b0;
        end

        assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign bus.rd_busy[k] = rb;
    end

    assign bus.any_busy = |busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass/2-write build (a)
// and non-bypass/1-write build (b).
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5),
                    .NUM_RD(2), .NUM_WR(2)) a ();
    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5),
                    .NUM_RD(2), .NUM_WR(1)) b ();

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2),
                 .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst), .bus(a.slave));

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2),
                 .NUM_WR(1), .ZERO_REG(1), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a.wr_en = '0; a.wr_addr = '0; a.wr_data = '0;
        a.iss_en = 1'b0; a.iss_addr = '0;
        b.wr_en = '0; b.wr_addr = '0; b.wr_data = '0;
        b.iss_en = 1'b0; b.iss_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        a.rd_addr = {5'd0, 5'd5};
        b.rd_addr = {5'd0, 5'd5};
        a.wr_en = 2'b11;
        a.wr_addr = {5'd5, 5'd5};
        a.wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        a.iss_en = 1'b1; a.iss_addr = 5'd5;
        b.wr_en = 1'b1; b.wr_addr = 5'd5; b.wr_data = 32'hFFFF_FFFF;
        b.iss_en = 1'b1; b.iss_addr = 5'd5;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle();
        #1;
        nvec++;
        if (a.rd_data !== 64'h0) begin
            nerr++;
            $display("FAIL reset_a_data got %h want 0", a.rd_data);
        end
        nvec++;
        if (a.rd_busy !== 2'b00 || a.any_busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_a_busy got %b/%b want 00/0",
                     a.rd_busy, a.any_busy);
        end
        nvec++;
        if (b.rd_data !== 64'h0 || b.any_busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_b got %h/%b want 0/0",
                     b.rd_data, b.any_busy);
        end
    endtask

    task automatic test_write_r0();
        idle();
        a.wr_en = 2'b11;
        a.wr_addr = {5'd0, 5'd5};
        a.wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
        a.rd_addr = {5'd0, 5'd0};
        #1;
        nvec++;
        if (a.rd_data[63:32] !== 32'h0) begin
            nerr++;
            $display("FAIL r0_no_bypass got %h want 0", a.rd_data[63:32]);
        end
        tick();
        idle();
        a.rd_addr = {5'd0, 5'd5};
        #1;
        nvec++;
        if (a.rd_data[31:0] !== 32'hDEAD_BEEF) begin
            nerr++;
            $display("FAIL wr_r5 got %h want deadbeef", a.rd_data[31:0]);
        end
        nvec++;
        if (a.rd_data[63:32] !== 32'h0) begin
            nerr++;
            $display("FAIL rd_r0 got %h want 0", a.rd_data[63:32]);
        end
    endtask

    task automatic test_bypass();
        idle();
        a.wr_en = 2'b01; a.wr_addr = {5'd0, 5'd7};
        a.wr_data = {32'h0, 32'hA5A5_A5A5};
        a.rd_addr = {5'd7, 5'd0};
        b.wr_en = 1'b1; b.wr_addr = 5'd7; b.wr_data = 32'hA5A5_A5A5;
        b.rd_addr = {5'd7, 5'd0};
        #1;
        nvec++;
        if (a.rd_data[63:32] !== 32'hA5A5_A5A5) begin
            nerr++;
            $display("FAIL bypass_a got %h want a5a5a5a5", a.rd_data[63:32]);
        end
        nvec++;
        if (b.rd_data[63:32] !== 32'h0) begin
            nerr++;
            $display("FAIL nobypass_b_old got %h want 0", b.rd_data[63:32]);
        end
        tick();
        idle();
        #1;
        nvec++;
        if (a.rd_data[63:32] !== 32'hA5A5_A5A5) begin
            nerr++;
            $display("FAIL bypass_a_held got %h want a5a5a5a5",
                     a.rd_data[63:32]);
        end
        nvec++;
        if (b.rd_data[63:32] !== 32'hA5A5_A5A5) begin
            nerr++;
            $display("FAIL nobypass_b_new got %h want a5a5a5a5",
                     b.rd_data[63:32]);
        end
    endtask

    task automatic test_collision();
        idle();
        a.wr_en = 2'b11; a.wr_addr = {5'd3, 5'd3};
        a.wr_data = {32'h2, 32'h1};
        a.rd_addr = {5'd0, 5'd3};
        #1;
        nvec++;
        if (a.rd_data[31:0] !== 32'h2) begin
            nerr++;
            $display("FAIL collide_bypass got %h want 2", a.rd_data[31:0]);
        end
        tick();
        idle();
        #1;
        nvec++;
        if (a.rd_data[31:0] !== 32'h2) begin
            nerr++;
            $display("FAIL collide_store got %h want 2", a.rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        a.rd_addr = {5'd0, 5'd9};
        a.iss_en = 1'b1; a.iss_addr = 5'd9;
        tick();
        idle();
        #1;
        nvec++;
        if (a.rd_busy !== 2'b01 || a.any_busy !== 1'b1) begin
            nerr++;
            $display("FAIL iss_busy got %b/%b want 01/1",
                     a.rd_busy, a.any_busy);
        end
        a.wr_en = 2'b01; a.wr_addr = {5'd0, 5'd9};
        a.wr_data = {32'h0, 32'h99};
        #1;
        nvec++;
        if (a.rd_busy[0] !== 1'b1) begin
            nerr++;
            $display("FAIL busy_not_bypassed got %b want 1", a.rd_busy[0]);
        end
        tick();
        idle();
        #1;
        nvec++;
        if (a.rd_busy !== 2'b00 || a.any_busy !== 1'b0 ||
            a.rd_data[31:0] !== 32'h99) begin
            nerr++;
            $display("FAIL wb_clear got %b/%b/%h want 00/0/99",
                     a.rd_busy, a.any_busy, a.rd_data[31:0]);
        end
        a.iss_en = 1'b1; a.iss_addr = 5'd9;
        tick();
        a.wr_en = 2'b01; a.wr_addr = {5'd0, 5'd9};
        a.wr_data = {32'h0, 32'hAB};
        tick();
        idle();
        #1;
        nvec++;
        if (a.rd_busy[0] !== 1'b1 || a.rd_data[31:0] !== 32'hAB) begin
            nerr++;
            $display("FAIL iss_wins got %b/%h want 1/ab",
                     a.rd_busy[0], a.rd_data[31:0]);
        end
        a.wr_en = 2'b10; a.wr_addr = {5'd9, 5'd0};
        a.wr_data = {32'hAC, 32'h0};
        tick();
        idle();
        a.rd_addr = {5'd0, 5'd9};
        a.iss_en = 1'b1; a.iss_addr = 5'd0;
        tick();
        idle();
        #1;
        nvec++;
        if (a.rd_busy !== 2'b00 || a.any_busy !== 1'b0) begin
            nerr++;
            $display("FAIL r0_never_busy got %b/%b want 00/0",
                     a.rd_busy, a.any_busy);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        a.rd_addr = {5'd4, 5'd4};
        a.iss_en = 1'b1; a.iss_addr = 5'd4;
        a.wr_en = 2'b01; a.wr_addr = {5'd0, 5'd4};
        a.wr_data = {32'h0, 32'h55};
        tick();
        idle();
        #1;
        nvec++;
        if (a.rd_busy !== 2'b11 || a.rd_data[31:0] !== 32'h55) begin
            nerr++;
            $display("FAIL pre_rst got %b/%h want 11/55",
                     a.rd_busy, a.rd_data[31:0]);
        end
        rst = 1'b1;
        a.wr_en = 2'b01; a.wr_data = {32'h0, 32'h66};
        tick();
        rst = 1'b0;
        idle();
        #1;
        nvec++;
        if (a.rd_data !== 64'h0 || a.rd_busy !== 2'b00 ||
            a.any_busy !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid got %h/%b/%b want 0/00/0",
                     a.rd_data, a.rd_busy, a.any_busy);
        end
    endtask

    initial begin
        idle();
        a.rd_addr = '0;
        b.rd_addr = '0;
        #2;
        test_reset();
        test_write_r0();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
